// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - row-major tile sequencer feeding the 32x32 rasteriser and the tile flush
// Build option: TILE_CULL_EN adds a per-tile reject stage for tiles wholly outside one edge.
module tile_scheduler #(
  parameter int TILE_BITS = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic [18:0]          A01_in,
  input  logic [18:0]          A12_in,
  input  logic [18:0]          A20_in,
  input  logic [23:0]          B01_in,
  input  logic [23:0]          B12_in,
  input  logic [23:0]          B20_in,
  input  logic [31:0]          w0_in,
  input  logic [31:0]          w1_in,
  input  logic [31:0]          w2_in,
  input  logic [15:0]          color_in,
  input  logic [TILE_BITS-1:0] tx_min,
  input  logic [TILE_BITS-1:0] tx_max,
  input  logic [TILE_BITS-1:0] ty_min,
  input  logic [TILE_BITS-1:0] ty_max,
  output logic                 tr_start,
  output logic [18:0]          tr_A01,
  output logic [18:0]          tr_A12,
  output logic [18:0]          tr_A20,
  output logic [23:0]          tr_B01,
  output logic [23:0]          tr_B12,
  output logic [23:0]          tr_B20,
  output logic [31:0]          tr_w0,
  output logic [31:0]          tr_w1,
  output logic [31:0]          tr_w2,
  output logic [15:0]          tr_color,
  input  logic                 tr_done,
  output logic                 flush_valid,
  input  logic                 flush_ready,
  output logic [TILE_BITS-1:0] flush_tx,
  output logic [TILE_BITS-1:0] flush_ty,
  output logic                 busy
);

  localparam int PAD = 32 - TILE_BITS;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_BASE,
    S_ISSUE,
    S_GAP,
    S_WAIT,
    S_FLUSH,
    S_NEXT
`ifdef TILE_CULL_EN
    , S_CULL
`endif
  } state_t;

`ifdef TILE_CULL_EN
  localparam state_t S_TILE = S_CULL;
`else
  localparam state_t S_TILE = S_ISSUE;
`endif

  state_t state_q, state_d;

  logic [18:0]          a_in  [3];
  logic [23:0]          b_in  [3];
  logic [31:0]          w_in  [3];
  logic [18:0]          a_q   [3];
  logic [23:0]          b_q   [3];
  logic [31:0]          w_q   [3];
  logic [31:0]          tx_step [3];
  logic [31:0]          ty_step [3];
  logic [31:0]          row_w [3];
  logic [31:0]          cur_w [3];
  logic [31:0]          a_ext [3];
  logic [31:0]          b_ext [3];
  logic [31:0]          r_calc [3];
  logic [31:0]          base_w [3];
  logic [15:0]          color_q;
  logic [TILE_BITS-1:0] tx_min_q, tx_max_q, ty_min_q, ty_max_q;
  logic [TILE_BITS-1:0] tx_q, ty_q;
  logic [31:0]          tx_min_ext, ty_min_ext;
  logic                 box_empty, last_col, last_row;

  assign a_in[0] = A01_in;
  assign a_in[1] = A12_in;
  assign a_in[2] = A20_in;
  assign b_in[0] = B01_in;
  assign b_in[1] = B12_in;
  assign b_in[2] = B20_in;
  assign w_in[0] = w0_in;
  assign w_in[1] = w1_in;
  assign w_in[2] = w2_in;

  assign tx_min_ext = {{PAD{1'b0}}, tx_min_q};
  assign ty_min_ext = {{PAD{1'b0}}, ty_min_q};
  assign box_empty  = (tx_min_q > tx_max_q) || (ty_min_q > ty_max_q);
  assign last_col   = (tx_q == tx_max_q);
  assign last_row   = (ty_q == ty_max_q);

  // Row step R = B + 31*A; bbox coordinates are unsigned multipliers of the signed steps
  always_comb begin
    for (int e = 0; e < 3; e++) begin
      a_ext[e]  = {{13{a_q[e][18]}}, a_q[e]};
      b_ext[e]  = {{8{b_q[e][23]}}, b_q[e]};
      r_calc[e] = b_ext[e] + (a_ext[e] << 5) - a_ext[e];
      base_w[e] = w_q[e] + tx_min_ext * tx_step[e] + ty_min_ext * ty_step[e];
    end
  end

`ifdef TILE_CULL_EN
  logic [31:0] r_q [3];
  logic [31:0] c10 [3];
  logic [31:0] c01 [3];
  logic [31:0] c11 [3];
  logic        cull_reject;

  // A tile is dropped when every corner of one edge is negative
  always_comb begin
    cull_reject = 1'b0;
    for (int e = 0; e < 3; e++) begin
      c10[e] = cur_w[e] + tx_step[e] - a_ext[e];
      c01[e] = cur_w[e] + ty_step[e] - r_q[e];
      c11[e] = c10[e] + ty_step[e] - r_q[e];
      if (cur_w[e][31] && c10[e][31] && c01[e][31] && c11[e][31])
        cull_reject = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tri_valid) state_d = S_SETUP;
      S_SETUP: state_d = S_BASE;
      S_BASE:  state_d = box_empty ? S_IDLE : S_TILE;
`ifdef TILE_CULL_EN
      S_CULL:  state_d = cull_reject ? S_NEXT : S_ISSUE;
`endif
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_WAIT;
      S_WAIT:  if (tr_done) state_d = S_FLUSH;
      S_FLUSH: if (flush_ready) state_d = S_NEXT;
      S_NEXT:  state_d = (last_col && last_row) ? S_IDLE : S_TILE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < 3; e++) begin
        a_q[e]     <= '0;
        b_q[e]     <= '0;
        w_q[e]     <= '0;
        tx_step[e] <= '0;
        ty_step[e] <= '0;
        row_w[e]   <= '0;
        cur_w[e]   <= '0;
`ifdef TILE_CULL_EN
        r_q[e]     <= '0;
`endif
      end
      color_q  <= '0;
      tx_min_q <= '0;
      tx_max_q <= '0;
      ty_min_q <= '0;
      ty_max_q <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tri_valid) begin
            for (int e = 0; e < 3; e++) begin
              a_q[e] <= a_in[e];
              b_q[e] <= b_in[e];
              w_q[e] <= w_in[e];
            end
            color_q  <= color_in;
            tx_min_q <= tx_min;
            tx_max_q <= tx_max;
            ty_min_q <= ty_min;
            ty_max_q <= ty_max;
          end
        end
        S_SETUP: begin
          for (int e = 0; e < 3; e++) begin
            tx_step[e] <= a_ext[e] << 5;
            ty_step[e] <= r_calc[e] << 5;
`ifdef TILE_CULL_EN
            r_q[e]     <= r_calc[e];
`endif
          end
        end
        S_BASE: begin
          for (int e = 0; e < 3; e++) begin
            row_w[e] <= base_w[e];
            cur_w[e] <= base_w[e];
          end
          tx_q <= tx_min_q;
          ty_q <= ty_min_q;
        end
        S_NEXT: begin
          if (!last_col) begin
            tx_q <= tx_q + TILE_BITS'(1);
            for (int e = 0; e < 3; e++) cur_w[e] <= cur_w[e] + tx_step[e];
          end else if (!last_row) begin
            ty_q <= ty_q + TILE_BITS'(1);
            tx_q <= tx_min_q;
            for (int e = 0; e < 3; e++) begin
              row_w[e] <= row_w[e] + ty_step[e];
              cur_w[e] <= row_w[e] + ty_step[e];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tri_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tr_start    = (state_q == S_ISSUE);
  assign flush_valid = (state_q == S_FLUSH);
  assign flush_tx    = tx_q;
  assign flush_ty    = ty_q;

  assign tr_A01   = a_q[0];
  assign tr_A12   = a_q[1];
  assign tr_A20   = a_q[2];
  assign tr_B01   = b_q[0];
  assign tr_B12   = b_q[1];
  assign tr_B20   = b_q[2];
  assign tr_w0    = cur_w[0];
  assign tr_w1    = cur_w[1];
  assign tr_w2    = cur_w[2];
  assign tr_color = color_q;

endmodule
